// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of an asynchronous 8-bit SRAM with a fixed-length access strobe.
// Define SRAM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sram_arbiter #(
  parameter int AW          = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cs0,
  input  logic          i_we0,
  input  logic [AW-1:0] i_addr0,
  input  logic [7:0]    i_data0,
  input  logic          i_cs1,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr1,
  input  logic [7:0]    i_data1,
  output logic          o_ack0,
  output logic          o_ack1,
  output logic [7:0]    o_data,
  output logic [AW-1:0] o_sram_addr,
  output logic [7:0]    o_sram_dout,
  input  logic [7:0]    i_sram_din,
  output logic          o_sram_cs,
  output logic          o_sram_we,
  output logic          o_sram_oe,
  output logic          o_sram_dout_en,
  output logic          o_busy,
  output logic          o_grant
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic          lat_we, lat_we_n;
  logic [AW-1:0] addr_n;
  logic [7:0]    dout_n;
  logic [7:0]    data_n;
  logic          grant_n;
  logic          win;
  logic          active_n;

`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
  logic last, last_n;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    lat_we_n = lat_we;
    addr_n   = o_sram_addr;
    dout_n   = o_sram_dout;
    data_n   = o_data;
    grant_n  = o_grant;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
    last_n   = last;
    win      = (i_cs0 && i_cs1) ? ~last : i_cs1;
`else
    win      = i_cs1 && !i_cs0;
`endif
    case (state)
      IDLE: begin
        if (i_cs0 || i_cs1) begin
          state_n  = SETUP;
          grant_n  = win;
          lat_we_n = win ? i_we1   : i_we0;
          addr_n   = win ? i_addr1 : i_addr0;
          dout_n   = win ? i_data1 : i_data0;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
          last_n   = win;
`endif
        end
      end
      SETUP: begin
        state_n = ACCESS;
        cnt_n   = 4'(WAIT_CYCLES - 1);
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_n = DONE;
          if (!lat_we) data_n = i_sram_din;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    active_n = (state_n == SETUP) || (state_n == ACCESS);
  end

  // Strobes are decoded from the next state so every output comes straight off a flop.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_we         <= 1'b0;
      o_sram_addr    <= '0;
      o_sram_dout    <= '0;
      o_data         <= '0;
      o_grant        <= 1'b0;
      o_sram_cs      <= 1'b0;
      o_sram_we      <= 1'b0;
      o_sram_oe      <= 1'b0;
      o_sram_dout_en <= 1'b0;
      o_ack0         <= 1'b0;
      o_ack1         <= 1'b0;
      o_busy         <= 1'b0;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
      last           <= 1'b1;
`endif
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      lat_we         <= lat_we_n;
      o_sram_addr    <= addr_n;
      o_sram_dout    <= dout_n;
      o_data         <= data_n;
      o_grant        <= grant_n;
      o_sram_cs      <= active_n;
      o_sram_we      <= (state_n == ACCESS) && lat_we_n;
      o_sram_oe      <= active_n && !lat_we_n;
      o_sram_dout_en <= active_n && lat_we_n;
      o_ack0         <= (state_n == DONE) && !grant_n;
      o_ack1         <= (state_n == DONE) && grant_n;
      o_busy         <= (state_n != IDLE);
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
      last           <= last_n;
`endif
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: cycle-phase reference model with per-cycle compare, plus directed
// literal checks at WAIT_CYCLES=2 and a second instance at WAIT_CYCLES=15.
module tb_sram_arbiter;

  localparam int MW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs0, we0, cs1, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  data0, data1;
  logic        ack0, ack1;
  logic [7:0]  rdata, sdout, sdin;
  logic [15:0] saddr;
  logic        scs, swe, soe, sden, busy, grant;

  logic        c15_cs, c15_we;
  logic [15:0] c15_addr;
  logic [7:0]  c15_data;
  logic        a15_0, a15_1, s15_cs, s15_we, s15_oe, s15_den, b15, g15;
  logic [7:0]  r15, d15_out, d15_in;
  logic [15:0] s15_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.AW(16), .WAIT_CYCLES(MW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cs0(cs0), .i_we0(we0), .i_addr0(addr0), .i_data0(data0),
    .i_cs1(cs1), .i_we1(we1), .i_addr1(addr1), .i_data1(data1),
    .o_ack0(ack0), .o_ack1(ack1), .o_data(rdata),
    .o_sram_addr(saddr), .o_sram_dout(sdout), .i_sram_din(sdin),
    .o_sram_cs(scs), .o_sram_we(swe), .o_sram_oe(soe), .o_sram_dout_en(sden),
    .o_busy(busy), .o_grant(grant)
  );

  sram_arbiter #(.AW(16), .WAIT_CYCLES(15)) dut15 (
    .i_clk(clk), .i_reset(rst),
    .i_cs0(c15_cs), .i_we0(c15_we), .i_addr0(c15_addr), .i_data0(c15_data),
    .i_cs1(1'b0), .i_we1(1'b0), .i_addr1(16'h0000), .i_data1(8'h00),
    .o_ack0(a15_0), .o_ack1(a15_1), .o_data(r15),
    .o_sram_addr(s15_addr), .o_sram_dout(d15_out), .i_sram_din(d15_in),
    .o_sram_cs(s15_cs), .o_sram_we(s15_we), .o_sram_oe(s15_oe), .o_sram_dout_en(s15_den),
    .o_busy(b15), .o_grant(g15)
  );

  // Board-level SRAM models
  logic [7:0] sram [0:65535];
  always @(posedge clk) if (swe) sram[saddr] <= sdout;
  assign sdin   = soe ? sram[saddr] : 8'h00;
  assign d15_in = s15_oe ? (s15_addr[7:0] ^ 8'h5A) : 8'h00;

  // Reference model: mph counts cycles since the grant (0 = idle, 1 = setup, MW+2 = done)
  int          mph = 0;
  logic        mg, mwe, mvalid = 1'b0;
  logic [7:0]  md, mo;
  logic [15:0] ma;
  logic [7:0]  mmem [0:65535];
  logic        m_w;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
  logic mlast;
  assign m_w = (cs0 && cs1) ? ~mlast : cs1;
`else
  assign m_w = cs1 && !cs0;
`endif

  always @(posedge clk) begin
    if (rst) begin
      mph <= 0; mg <= 1'b0; mwe <= 1'b0; md <= 8'h00; mo <= 8'h00; ma <= 16'h0000;
      mvalid <= 1'b1;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
      mlast <= 1'b1;
`endif
    end else if (mph == 0) begin
      if (cs0 || cs1) begin
        mph <= 1;
        mg  <= m_w;
        mwe <= m_w ? we1 : we0;
        ma  <= m_w ? addr1 : addr0;
        mo  <= m_w ? data1 : data0;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
        mlast <= m_w;
`endif
      end
    end else if (mph == MW + 2) begin
      mph <= 0;
    end else begin
      mph <= mph + 1;
      if (mph == MW + 1) begin
        if (mwe) mmem[ma] <= mo;
        else     md <= mmem[ma];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_sram_cs",  32'(scs),  32'(mph >= 1 && mph <= MW + 1));
      chk("m_sram_we",  32'(swe),  32'(mwe && mph >= 2 && mph <= MW + 1));
      chk("m_sram_oe",  32'(soe),  32'(!mwe && mph >= 1 && mph <= MW + 1));
      chk("m_dout_en",  32'(sden), 32'(mwe && mph >= 1 && mph <= MW + 1));
      chk("m_ack0",     32'(ack0), 32'(mph == MW + 2 && !mg));
      chk("m_ack1",     32'(ack1), 32'(mph == MW + 2 && mg));
      chk("m_busy",     32'(busy), 32'(mph != 0));
      chk("m_grant",    32'(grant), 32'(mg));
      chk("m_data",     32'(rdata), 32'(md));
      chk("m_sram_addr", 32'(saddr), 32'(ma));
      chk("m_sram_dout", 32'(sdout), 32'(mo));
    end
  end

  int ac, wc, oc, dc;
  bit aok;

  task automatic do_txn(input int port, input bit w, input logic [15:0] a, input logic [7:0] d,
                        input bit drop_early, output int ack_cyc, output int we_cnt,
                        output int oe_cnt, output int den_cnt, output bit addr_ok);
    int cyc = 0;
    ack_cyc = -1; we_cnt = 0; oe_cnt = 0; den_cnt = 0; addr_ok = 1'b1;
    @(negedge clk);
    if (port == 0) begin cs0 = 1'b1; we0 = w; addr0 = a; data0 = d; end
    else           begin cs1 = 1'b1; we1 = w; addr1 = a; data1 = d; end
    while (cyc < 40 && ack_cyc < 0) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (swe)  we_cnt++;
      if (soe)  oe_cnt++;
      if (sden) den_cnt++;
      if (scs && saddr != a) addr_ok = 1'b0;
      if (drop_early && cyc == 1) begin
        if (port == 0) begin cs0 = 1'b0; addr0 = 16'hFFFF; data0 = 8'h00; end
        else           begin cs1 = 1'b0; addr1 = 16'hFFFF; data1 = 8'h00; end
      end
      if ((port == 0) ? ack0 : ack1) ack_cyc = cyc;
    end
    if (port == 0) cs0 = 1'b0; else cs1 = 1'b0;
  endtask

  int aport [4];
  int acyc  [4];
  int nacks, cyc;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i] = 8'h00;
      mmem[i] = 8'h00;
    end
    rst = 1'b1;
    cs0 = 1'b0; we0 = 1'b0; addr0 = 16'h0000; data0 = 8'h00;
    cs1 = 1'b0; we1 = 1'b0; addr1 = 16'h0000; data1 = 8'h00;
    c15_cs = 1'b0; c15_we = 1'b0; c15_addr = 16'h0000; c15_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(rdata), 32'h00);
    chk("rst_addr", 32'(saddr), 32'h0000);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_strobes", {28'd0, scs, swe, soe, sden}, 32'd0);
    chk("rst_acks", {30'd0, ack0, ack1}, 32'd0);
    rst = 1'b0;

    // Port 0 write
    do_txn(0, 1'b1, 16'h0123, 8'hA5, 1'b0, ac, wc, oc, dc, aok);
    chk("wr_ack_cycle", 32'(ac), 32'd4);
    chk("wr_we_cycles", 32'(wc), 32'd2);
    chk("wr_den_cycles", 32'(dc), 32'd3);
    chk("wr_oe_cycles", 32'(oc), 32'd0);
    chk("wr_addr", 32'(aok), 32'd1);
    chk("wr_mem", 32'(sram[16'h0123]), 32'hA5);

    // Port 1 read back
    do_txn(1, 1'b0, 16'h0123, 8'h00, 1'b0, ac, wc, oc, dc, aok);
    chk("rd_ack_cycle", 32'(ac), 32'd4);
    chk("rd_oe_cycles", 32'(oc), 32'd3);
    chk("rd_we_cycles", 32'(wc), 32'd0);
    chk("rd_data", 32'(rdata), 32'hA5);

    // Port 0 write, request dropped after setup
    do_txn(0, 1'b1, 16'h0200, 8'h3C, 1'b1, ac, wc, oc, dc, aok);
    chk("drop_ack_cycle", 32'(ac), 32'd4);
    chk("drop_addr", 32'(aok), 32'd1);
    chk("drop_mem", 32'(sram[16'h0200]), 32'h3C);
    chk("drop_data_held", 32'(rdata), 32'hA5);

    // Reset during ACCESS
    @(negedge clk);
    cs0 = 1'b1; we0 = 1'b0; addr0 = 16'h0123;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1; cs0 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_strobes", {28'd0, scs, swe, soe, sden}, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    nacks = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (ack0 || ack1) nacks++;
    end
    chk("abort_no_ack", 32'(nacks), 32'd0);
    do_txn(0, 1'b0, 16'h0200, 8'h00, 1'b0, ac, wc, oc, dc, aok);
    chk("fresh_ack_cycle", 32'(ac), 32'd4);
    chk("fresh_data", 32'(rdata), 32'h3C);

    // Both ports requesting continuously
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk); rst = 1'b0;
    cs0 = 1'b1; we0 = 1'b0; addr0 = 16'h0123;
    cs1 = 1'b1; we1 = 1'b0; addr1 = 16'h0200;
    for (int i = 0; i < 4; i++) begin aport[i] = -1; acyc[i] = -1; end
    nacks = 0; cyc = 0;
    while (nacks < 4 && cyc < 60) begin
      @(posedge clk); cyc++; @(negedge clk);
      if (ack0 && nacks < 4) begin aport[nacks] = 0; acyc[nacks] = cyc; nacks++; end
      if (ack1 && nacks < 4) begin aport[nacks] = 1; acyc[nacks] = cyc; nacks++; end
    end
    cs0 = 1'b0; cs1 = 1'b0;
    chk("arb_first_cycle", 32'(acyc[0]), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
      chk("arb_port", 32'(aport[i]), 32'(i % 2));
`else
      chk("arb_port", 32'(aport[i]), 32'd0);
`endif
      if (i > 0) chk("arb_period", 32'(acyc[i] - acyc[i-1]), 32'd5);
    end

    // WAIT_CYCLES=15 read on the second instance
    @(negedge clk);
    c15_cs = 1'b1; c15_we = 1'b0; c15_addr = 16'h0042;
    ac = -1; cyc = 0;
    while (cyc < 60 && ac < 0) begin
      @(posedge clk); cyc++; @(negedge clk);
      if (a15_0) ac = cyc;
    end
    c15_cs = 1'b0;
    chk("w15_ack_cycle", 32'(ac), 32'd17);
    chk("w15_data", 32'(r15), 32'h18);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter AW, default 16: address width of both requester ports and the SRAM address.
REQ-002 Parameter WAIT_CYCLES, default 2, legal range 1..15: length of the SRAM access strobe in i_clk cycles.
REQ-003 i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 Per port n in {0,1}: i_cs<n> in 1 request; i_we<n> in 1 write (1) or read (0); i_addr<n> in AW; i_data<n> in 8 write data.
REQ-006 Per port n: o_ack<n> out 1 one-cycle completion pulse; o_data out 8 read data, shared by both ports.
REQ-007 o_sram_addr out AW; o_sram_dout out 8; i_sram_din in 8.
REQ-008 o_sram_cs, o_sram_we, o_sram_oe, o_sram_dout_en: out, 1 bit each, active-high; board-level inversion is outside this block.
REQ-009 o_busy out 1 (transaction in progress); o_grant out 1 (owning port, valid while o_busy).

Function
REQ-010 FSM states: IDLE, SETUP, ACCESS, DONE; all outputs registered.
REQ-011 IDLE: with any i_cs<n> high, latch winner, its i_we/i_addr/i_data, go SETUP; otherwise stay IDLE.
REQ-012 SETUP, 1 cycle: o_sram_cs=1, o_sram_addr valid, o_sram_we=0; o_sram_dout_en=1 for writes; o_sram_oe=1 for reads; next ACCESS.
REQ-013 ACCESS, exactly WAIT_CYCLES cycles (4-bit down-counter): signals as SETUP plus o_sram_we=1 for writes.
REQ-014 Reads capture i_sram_din into o_data on the last ACCESS cycle.
REQ-015 DONE, 1 cycle: o_sram_cs/we/oe/dout_en=0; o_ack<grant>=1; next IDLE.
REQ-016 Latency: request sampled in IDLE at cycle 0 -> o_ack at cycle WAIT_CYCLES+2; back-to-back throughput one access per WAIT_CYCLES+3 cycles.
REQ-017 o_data holds its value until the next completed read; writes leave it unchanged.
REQ-018 Requester holds i_cs and its inputs until o_ack and drops i_cs the cycle after o_ack; dropping i_cs mid-transaction does not abort it (ack still pulses).
REQ-019 Changes on latched inputs during SETUP/ACCESS/DONE are ignored.
REQ-020 Loser of a simultaneous request is served on the next IDLE; no request is dropped.
REQ-021 o_busy=1 in SETUP, ACCESS, DONE; 0 in IDLE.
REQ-022 o_sram_addr/o_sram_dout retain the last latched values while IDLE.

Reset
REQ-023 i_reset: state IDLE; o_sram_cs/we/oe/dout_en=0; o_ack0=o_ack1=0; o_busy=0; o_grant=0; o_data=8'h00; o_sram_addr=0; o_sram_dout=0; RR pointer "last=1".
REQ-024 Reset mid-transaction aborts it: no ack, SRAM strobes low on the following cycle.

Configuration
REQ-025 Macro SRAM_ARBITER_ROUND_ROBIN_EN defined: on simultaneous request, grant port != last-granted; pointer updated on each grant; port 0 wins first after reset.
REQ-026 Macro undefined: fixed priority, port 0 always wins simultaneous requests; no pointer register.

Verification (WAIT_CYCLES=2)
REQ-027 Port0 write addr 16'h0123 data 8'hA5 -> o_sram_we high exactly 2 cycles with dout_en, addr 0123; o_ack0 at cycle 4.
REQ-028 Port1 read addr 16'h0123 from SRAM model holding 8'hA5 -> o_sram_oe 3 cycles, o_ack1 at cycle 4, o_data=8'hA5.
REQ-029 Both ports request continuously, RR_EN defined -> grants 0,1,0,1; one ack each per 5 cycles; undefined -> port 0 acks only.
REQ-030 i_reset pulsed during ACCESS -> no o_ack, strobes 0 next cycle, fresh request served normally.
REQ-031 Port0 drops i_cs after SETUP -> transaction completes, o_ack0 pulses at cycle 4, SRAM written.
REQ-032 WAIT_CYCLES=15 read -> o_ack at cycle 17, o_data correct.
